// File: rtl/alu_dcache_decoder.sv
// LEGv8 single-cycle slice: instruction decoder, ALU and a word-addressed data cache.
// Everything is combinational except the cache array, which clears asynchronously on reset.
module alu_dcache_decoder #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [31:0] read_data1,
   input  logic [31:0] read_data2,
   output logic        reg2loc,
   output logic        uncond_branch,
   output logic        branch,
   output logic        mem_read,
   output logic        mem_to_reg,
   output logic        mem_write,
   output logic        alu_src,
   output logic        reg_write,
   output logic        illegal,
   output logic [3:0]  alu_ctrl,
   output logic [4:0]  rn,
   output logic [4:0]  rm,
   output logic [4:0]  rt,
   output logic [4:0]  read_reg2,
   output logic [31:0] sign_ext,
   output logic [31:0] alu_result,
   output logic        zero,
   output logic [31:0] mem_data,
   output logic [31:0] write_back
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [9:0]  OP_ADDI = 10'b1001000100;
   localparam logic [9:0]  OP_SUBI = 10'b1101000100;
   localparam logic [7:0]  OP_CBZ  = 8'b10110100;
   localparam logic [5:0]  OP_B    = 6'b000101;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_ORR  = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_PASS = 4'b0111;

   logic [31:0]      alu_b;
   logic [IDX_W-1:0] index;
   logic [31:0]      mem_q [MEM_WORDS];

   assign rn        = instruction[9:5];
   assign rm        = instruction[20:16];
   assign rt        = instruction[4:0];
   assign read_reg2 = reg2loc ? rt : rm;

   always_comb begin
      reg2loc       = 1'b0;
      uncond_branch = 1'b0;
      branch        = 1'b0;
      mem_read      = 1'b0;
      mem_to_reg    = 1'b0;
      mem_write     = 1'b0;
      alu_src       = 1'b0;
      reg_write     = 1'b0;
      illegal       = 1'b0;
      alu_ctrl      = ALU_AND;
      sign_ext      = 32'd0;
      case (instruction[31:21])
         OP_ADD: begin reg_write = 1'b1; alu_ctrl = ALU_ADD; end
         OP_SUB: begin reg_write = 1'b1; alu_ctrl = ALU_SUB; end
         OP_AND: begin reg_write = 1'b1; alu_ctrl = ALU_AND; end
         OP_ORR: begin reg_write = 1'b1; alu_ctrl = ALU_ORR; end
         OP_LDUR: begin
            alu_src    = 1'b1;
            mem_read   = 1'b1;
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            alu_ctrl   = ALU_ADD;
            sign_ext   = {{23{instruction[20]}}, instruction[20:12]};
         end
         OP_STUR: begin
            reg2loc   = 1'b1;
            alu_src   = 1'b1;
            mem_write = 1'b1;
            alu_ctrl  = ALU_ADD;
            sign_ext  = {{23{instruction[20]}}, instruction[20:12]};
         end
         default: begin
            // Shorter opcodes only decode once no 11-bit opcode matched.
            if (instruction[31:22] == OP_ADDI || instruction[31:22] == OP_SUBI) begin
               alu_src   = 1'b1;
               reg_write = 1'b1;
               alu_ctrl  = (instruction[31:22] == OP_ADDI) ? ALU_ADD : ALU_SUB;
               sign_ext  = {20'd0, instruction[21:10]};
            end else if (instruction[31:24] == OP_CBZ) begin
               reg2loc  = 1'b1;
               branch   = 1'b1;
               alu_ctrl = ALU_PASS;
               sign_ext = {{13{instruction[23]}}, instruction[23:5]};
            end else if (instruction[31:26] == OP_B) begin
               uncond_branch = 1'b1;
               alu_ctrl      = ALU_ADD;
               sign_ext      = {{6{instruction[25]}}, instruction[25:0]};
            end else begin
               illegal = 1'b1;
            end
         end
      endcase
   end

   assign alu_b = alu_src ? sign_ext : read_data2;

   always_comb begin
      case (alu_ctrl)
         ALU_AND:  alu_result = read_data1 & alu_b;
         ALU_ORR:  alu_result = read_data1 | alu_b;
         ALU_ADD:  alu_result = read_data1 + alu_b;
         ALU_SUB:  alu_result = read_data1 - alu_b;
         ALU_PASS: alu_result = alu_b;
         default:  alu_result = 32'd0;
      endcase
   end

   assign zero = (alu_result == 32'd0);

   // Byte offset and bits above the index are dropped, so addresses alias modulo MEM_WORDS*4.
   assign index = alu_result[IDX_W+1:2];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= 32'd0;
      end else if (mem_write) begin
         mem_q[index] <= read_data2;
      end
   end

   assign mem_data   = mem_read ? mem_q[index] : 32'd0;
   assign write_back = mem_to_reg ? mem_data : alu_result;

endmodule

// File: tb/tb_alu_dcache_decoder.sv
// Directed bench for alu_dcache_decoder: decode, ALU, cache write/read, reset clear and aliasing.
module tb_alu_dcache_decoder;

   logic        clock;
   logic        reset;
   logic [31:0] instruction;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic        reg2loc, uncond_branch, branch, mem_read, mem_to_reg;
   logic        mem_write, alu_src, reg_write, illegal, zero;
   logic [3:0]  alu_ctrl;
   logic [4:0]  rn, rm, rt, read_reg2;
   logic [31:0] sign_ext, alu_result, mem_data, write_back;
   logic [8:0]  ctrl;

   int checks = 0;
   int errors = 0;

   alu_dcache_decoder #(.MEM_WORDS(32)) dut (
      .clock(clock), .reset(reset), .instruction(instruction),
      .read_data1(read_data1), .read_data2(read_data2),
      .reg2loc(reg2loc), .uncond_branch(uncond_branch), .branch(branch),
      .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
      .alu_src(alu_src), .reg_write(reg_write), .illegal(illegal),
      .alu_ctrl(alu_ctrl), .rn(rn), .rm(rm), .rt(rt), .read_reg2(read_reg2),
      .sign_ext(sign_ext), .alu_result(alu_result), .zero(zero),
      .mem_data(mem_data), .write_back(write_back)
   );

   // {reg2loc, uncond_branch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, illegal}
   assign ctrl = {reg2loc, uncond_branch, branch, mem_read, mem_to_reg,
                  mem_write, alu_src, reg_write, illegal};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] m,
                                         input logic [4:0] n, input logic [4:0] d);
      return {op, m, 6'd0, n, d};
   endfunction

   function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                         input logic [4:0] n, input logic [4:0] d);
      return {op, imm, n, d};
   endfunction

   function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] dt,
                                         input logic [4:0] n, input logic [4:0] t);
      return {op, dt, 2'b00, n, t};
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      instruction = ins;
      read_data1  = a;
      read_data2  = b;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(enc_d(11'b11111000010, 9'd0, 5'd0, 5'd1), 32'd0, 32'd0);
      checks++; if (mem_data !== 32'd0) begin errors++; $display("FAIL reset_mem got %h exp %h", mem_data, 32'd0); end
      checks++; if (ctrl !== 9'b000110110) begin errors++; $display("FAIL reset_ldur_ctrl got %b exp %b", ctrl, 9'b000110110); end
      reset = 1'b0;
   endtask

   task automatic test_rtype;
      drive(enc_r(11'b10001011000, 5'd2, 5'd1, 5'd3), 32'd5, 32'd7);
      checks++; if (alu_ctrl !== 4'b0010) begin errors++; $display("FAIL add_aluctrl got %b exp %b", alu_ctrl, 4'b0010); end
      checks++; if (ctrl !== 9'b000000010) begin errors++; $display("FAIL add_ctrl got %b exp %b", ctrl, 9'b000000010); end
      checks++; if (alu_result !== 32'd12 || zero !== 1'b0) begin errors++; $display("FAIL add_result got %h/%b exp 0000000c/0", alu_result, zero); end
      checks++; if ({rn, rm, rt, read_reg2} !== {5'd1, 5'd2, 5'd3, 5'd2}) begin errors++; $display("FAIL add_fields got %h exp %h", {rn, rm, rt, read_reg2}, {5'd1, 5'd2, 5'd3, 5'd2}); end
      checks++; if (write_back !== 32'd12) begin errors++; $display("FAIL add_wb got %h exp %h", write_back, 32'd12); end
      drive(enc_r(11'b11001011000, 5'd2, 5'd1, 5'd3), 32'd9, 32'd9);
      checks++; if (alu_ctrl !== 4'b0110 || alu_result !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL sub_eq got %b/%h/%b exp 0110/00000000/1", alu_ctrl, alu_result, zero); end
      drive(enc_r(11'b10101010000, 5'd2, 5'd1, 5'd3), 32'hF0, 32'h0F);
      checks++; if (alu_ctrl !== 4'b0001 || alu_result !== 32'hFF) begin errors++; $display("FAIL orr got %b/%h exp 0001/000000ff", alu_ctrl, alu_result); end
      drive(enc_r(11'b10001010000, 5'd2, 5'd1, 5'd3), 32'hF0, 32'h3C);
      checks++; if (alu_ctrl !== 4'b0000 || alu_result !== 32'h30) begin errors++; $display("FAIL and got %b/%h exp 0000/00000030", alu_ctrl, alu_result); end
   endtask

   task automatic test_immediate;
      drive(enc_i(10'b1001000100, 12'hFFF, 5'd1, 5'd2), 32'd1, 32'h12345678);
      checks++; if (sign_ext !== 32'h00000FFF) begin errors++; $display("FAIL addi_ext got %h exp %h", sign_ext, 32'h00000FFF); end
      checks++; if (ctrl !== 9'b000000110 || alu_result !== 32'h1000) begin errors++; $display("FAIL addi got %b/%h exp 000000110/00001000", ctrl, alu_result); end
      drive(enc_i(10'b1101000100, 12'd1, 5'd1, 5'd2), 32'd0, 32'd0);
      checks++; if (alu_ctrl !== 4'b0110 || alu_result !== 32'hFFFFFFFF || zero !== 1'b0) begin errors++; $display("FAIL subi_wrap got %b/%h/%b exp 0110/ffffffff/0", alu_ctrl, alu_result, zero); end
   endtask

   task automatic test_store_load;
      drive(enc_d(11'b11111000000, 9'd4, 5'd1, 5'd4), 32'd8, 32'hDEADBEEF);
      checks++; if (ctrl !== 9'b100001100 || alu_result !== 32'd12) begin errors++; $display("FAIL stur_dec got %b/%h exp 100001100/0000000c", ctrl, alu_result); end
      checks++; if (read_reg2 !== 5'd4 || mem_data !== 32'd0) begin errors++; $display("FAIL stur_rr2 got %h/%h exp 04/00000000", read_reg2, mem_data); end
      @(posedge clock);
      drive(enc_d(11'b11111000010, 9'd4, 5'd1, 5'd5), 32'd8, 32'd0);
      checks++; if (mem_data !== 32'hDEADBEEF || write_back !== 32'hDEADBEEF) begin errors++; $display("FAIL ldur_read got %h/%h exp deadbeef/deadbeef", mem_data, write_back); end
      checks++; if (mem_to_reg !== 1'b1 || read_reg2 !== 5'd0) begin errors++; $display("FAIL ldur_ctl got %b/%h exp 1/00", mem_to_reg, read_reg2); end
      // Negative displacement reaching the same word.
      drive(enc_d(11'b11111000010, 9'h1FC, 5'd1, 5'd5), 32'd16, 32'd0);
      checks++; if (sign_ext !== 32'hFFFFFFFC || mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ldur_neg got %h/%h exp fffffffc/deadbeef", sign_ext, mem_data); end
   endtask

   task automatic test_branch;
      drive({8'b10110100, 19'h7FFFF, 5'd7}, 32'd3, 32'd0);
      checks++; if (sign_ext !== 32'hFFFFFFFF || ctrl !== 9'b101000000) begin errors++; $display("FAIL cbz_dec got %h/%b exp ffffffff/101000000", sign_ext, ctrl); end
      checks++; if (alu_ctrl !== 4'b0111 || zero !== 1'b1 || read_reg2 !== 5'd7) begin errors++; $display("FAIL cbz_zero got %b/%b/%h exp 0111/1/07", alu_ctrl, zero, read_reg2); end
      drive({8'b10110100, 19'd0, 5'd7}, 32'd3, 32'd5);
      checks++; if (alu_result !== 32'd5 || zero !== 1'b0) begin errors++; $display("FAIL cbz_nz got %h/%b exp 00000005/0", alu_result, zero); end
      drive({6'b000101, 26'h2000000}, 32'd1, 32'd2);
      checks++; if (sign_ext !== 32'hFE000000 || ctrl !== 9'b010000000 || alu_ctrl !== 4'b0010) begin errors++; $display("FAIL b_dec got %h/%b/%b exp fe000000/010000000/0010", sign_ext, ctrl, alu_ctrl); end
   endtask

   task automatic test_illegal;
      drive(32'h00000000, 32'd12, 32'h55555555);
      checks++; if (ctrl !== 9'b000000001 || alu_ctrl !== 4'b0000 || sign_ext !== 32'd0) begin errors++; $display("FAIL illegal_dec got %b/%b/%h exp 000000001/0000/00000000", ctrl, alu_ctrl, sign_ext); end
      @(posedge clock);
      drive(enc_d(11'b11111000010, 9'd0, 5'd1, 5'd5), 32'd12, 32'd0);
      checks++; if (mem_data !== 32'hDEADBEEF) begin errors++; $display("FAIL illegal_nowrite got %h exp %h", mem_data, 32'hDEADBEEF); end
   endtask

   task automatic test_reset_clear_alias;
      drive(enc_d(11'b11111000000, 9'd0, 5'd1, 5'd4), 32'd0, 32'h1234);
      @(posedge clock);
      drive(enc_d(11'b11111000010, 9'd0, 5'd1, 5'd5), 32'd0, 32'd0);
      checks++; if (mem_data !== 32'h1234) begin errors++; $display("FAIL pre_reset got %h exp %h", mem_data, 32'h1234); end
      #1 reset = 1'b1;
      #1;
      checks++; if (mem_data !== 32'd0 || alu_result !== 32'd0 || ctrl !== 9'b000110110) begin errors++; $display("FAIL async_clear got %h/%h/%b exp 00000000/00000000/000110110", mem_data, alu_result, ctrl); end
      // A store attempted while reset is held must not land.
      drive(enc_d(11'b11111000000, 9'd0, 5'd1, 5'd4), 32'd0, 32'h7777);
      @(posedge clock);
      drive(enc_d(11'b11111000010, 9'd0, 5'd1, 5'd5), 32'd0, 32'd0);
      reset = 1'b0;
      #1;
      checks++; if (mem_data !== 32'd0) begin errors++; $display("FAIL reset_blocks got %h exp %h", mem_data, 32'd0); end
      drive(enc_d(11'b11111000000, 9'd0, 5'd1, 5'd4), 32'd128, 32'hA5A5);
      @(posedge clock);
      drive(enc_d(11'b11111000010, 9'd0, 5'd1, 5'd5), 32'd0, 32'd0);
      checks++; if (mem_data !== 32'hA5A5) begin errors++; $display("FAIL alias_128 got %h exp %h", mem_data, 32'hA5A5); end
      drive(enc_d(11'b11111000010, 9'd0, 5'd1, 5'd5), 32'd2, 32'd0);
      checks++; if (mem_data !== 32'hA5A5) begin errors++; $display("FAIL byte_offset got %h exp %h", mem_data, 32'hA5A5); end
      drive(enc_d(11'b11111000010, 9'd0, 5'd1, 5'd5), 32'd12, 32'd0);
      checks++; if (mem_data !== 32'd0) begin errors++; $display("FAIL word3_cleared got %h exp %h", mem_data, 32'd0); end
   endtask

   initial begin
      reset       = 1'b1;
      instruction = 32'd0;
      read_data1  = 32'd0;
      read_data2  = 32'd0;
      test_reset;
      test_rtype;
      test_immediate;
      test_store_load;
      test_branch;
      test_illegal;
      test_reset_clear_alias;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
